// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch and load/store ports.
// One access is granted per cycle; read data returns READ_LAT cycles later on the owner's port.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,

  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,

  output logic              ram_ena,
  output logic [3:0]        ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,

  output logic              stall
);

  localparam logic [3:0] StarveLim = 4'(STARVE_MAX);

  logic                win_i;
  logic                win_d;
  logic                fetch_urgent;
  logic [3:0]          wait_cnt_q;
  logic [3:0]          wait_cnt_d;

  // Response pipeline: one {valid, owner} entry per RAM latency stage; owner 1 = data port.
  logic [READ_LAT-1:0] pipe_valid_q;
  logic [READ_LAT-1:0] pipe_valid_d;
  logic [READ_LAT-1:0] pipe_owner_q;
  logic [READ_LAT-1:0] pipe_owner_d;
  logic                push_valid;
  logic                head_valid;
  logic                head_owner;

  // Arbitration; everything is forced idle while reset is asserted.
  always_comb begin
    fetch_urgent = (wait_cnt_q == StarveLim);
    win_i        = 1'b0;
    win_d        = 1'b0;
    if (rst) begin
      if (i_req && d_req) begin
        win_i = fetch_urgent;
        win_d = !fetch_urgent;
      end else begin
        win_i = i_req;
        win_d = d_req;
      end
    end
  end

  assign i_gnt = win_i;
  assign d_gnt = win_d;
  assign stall = rst & ((i_req & ~win_i) | (d_req & ~win_d));

  // RAM drive from the winner of this cycle.
  always_comb begin
    ram_ena  = win_i | win_d;
    ram_wea  = 4'b0000;
    ram_addr = '0;
    ram_din  = 32'h0;
    if (win_d) begin
      ram_wea  = d_we;
      ram_addr = d_addr;
      ram_din  = d_wdata;
    end else if (win_i) begin
      ram_addr = i_addr;
    end
  end

  // Count consecutive cycles the fetch port was held off, saturating at the starvation limit.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!i_req || win_i) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != StarveLim) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // Writes still occupy a slot (as an empty entry) so ordering against the RAM stays aligned.
  always_comb begin
    push_valid      = win_i | (win_d & (d_we == 4'b0000));
    pipe_valid_d    = pipe_valid_q;
    pipe_owner_d    = pipe_owner_q;
    pipe_valid_d[0] = push_valid;
    pipe_owner_d[0] = win_d;
    for (int unsigned k = 1; k < READ_LAT; k++) begin
      pipe_valid_d[k] = pipe_valid_q[k-1];
      pipe_owner_d[k] = pipe_owner_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q   <= 4'd0;
      pipe_valid_q <= '0;
      pipe_owner_q <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_owner_q <= pipe_owner_d;
    end
  end

  assign head_valid = pipe_valid_q[READ_LAT-1];
  assign head_owner = pipe_owner_q[READ_LAT-1];

  always_comb begin
    i_rvalid = rst & head_valid & ~head_owner;
    d_rvalid = rst & head_valid & head_owner;
    i_rdata  = i_rvalid ? ram_dout : 32'h0;
    d_rdata  = d_rvalid ? ram_dout : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiters (READ_LAT 1 and 2) driven by shared stimulus, each with its
// own RAM, compared against a transaction-level model plus directed tables and sequences.
module tb_mem_port_arbiter;

  localparam int STARVE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req;
  logic [9:0]  i_addr, d_addr;
  logic [3:0]  d_we;
  logic [31:0] d_wdata;

  logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, ram_ena1, stall1;
  logic [31:0] i_rdata1, d_rdata1, ram_din1, ram_dout1;
  logic [3:0]  ram_wea1;
  logic [9:0]  ram_addr1;
  logic        i_gnt2, i_rvalid2, d_gnt2, d_rvalid2, ram_ena2, stall2;
  logic [31:0] i_rdata2, d_rdata2, ram_din2, ram_dout2;
  logic [3:0]  ram_wea2;
  logic [9:0]  ram_addr2;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(10), .READ_LAT(1), .STARVE_MAX(STARVE)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt1),
    .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .ram_ena(ram_ena1), .ram_wea(ram_wea1), .ram_addr(ram_addr1), .ram_din(ram_din1),
    .ram_dout(ram_dout1), .stall(stall1)
  );

  mem_port_arbiter #(.ADDR_W(10), .READ_LAT(2), .STARVE_MAX(STARVE)) dut2 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt2), .i_rvalid(i_rvalid2), .i_rdata(i_rdata2),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt2),
    .d_rvalid(d_rvalid2), .d_rdata(d_rdata2),
    .ram_ena(ram_ena2), .ram_wea(ram_wea2), .ram_addr(ram_addr2), .ram_din(ram_din2),
    .ram_dout(ram_dout2), .stall(stall2)
  );

  // Behavioural RAMs: 64 words is enough for every address the bench uses.
  logic [31:0] mem1 [64];
  logic [31:0] mem2 [64];
  logic [31:0] r1, r2a, r2b;

  always @(posedge clk) begin
    if (ram_ena1) begin
      for (int b = 0; b < 4; b++)
        if (ram_wea1[b]) mem1[ram_addr1[5:0]][8*b +: 8] <= ram_din1[8*b +: 8];
      r1 <= mem1[ram_addr1[5:0]];
    end
  end
  assign ram_dout1 = r1;

  always @(posedge clk) begin
    if (ram_ena2) begin
      for (int b = 0; b < 4; b++)
        if (ram_wea2[b]) mem2[ram_addr2[5:0]][8*b +: 8] <= ram_din2[8*b +: 8];
      r2a <= mem2[ram_addr2[5:0]];
    end
    r2b <= r2a;
  end
  assign ram_dout2 = r2b;

  typedef struct {
    logic gi; logic gd; logic ena; logic [3:0] wea; logic [9:0] addr; logic [31:0] din;
    logic stall; logic irv; logic [31:0] ird; logic drv; logic [31:0] drd;
  } outs_t;

  typedef struct { int due; bit own_d; logic [31:0] data; } resp_t;

  typedef struct {
    logic ir; logic [9:0] ia; logic dr; logic [3:0] dwe; logic [9:0] da; logic [31:0] dwd;
    logic egi; logic egd; logic [3:0] ewea; logic [9:0] eaddr; logic [31:0] edin; logic estall;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          m_wait = 0;
  bit          m_gi = 0, m_gd = 0;
  logic [31:0] ref_mem [64];
  resp_t       q1[$], q2[$];
  outs_t       a1, a2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp_outs(input string t, input outs_t a, input outs_t e);
    chk({t, ".i_gnt"}, 32'(a.gi), 32'(e.gi));
    chk({t, ".d_gnt"}, 32'(a.gd), 32'(e.gd));
    chk({t, ".ram_ena"}, 32'(a.ena), 32'(e.ena));
    chk({t, ".ram_wea"}, 32'(a.wea), 32'(e.wea));
    chk({t, ".ram_addr"}, 32'(a.addr), 32'(e.addr));
    chk({t, ".ram_din"}, a.din, e.din);
    chk({t, ".stall"}, 32'(a.stall), 32'(e.stall));
    chk({t, ".i_rvalid"}, 32'(a.irv), 32'(e.irv));
    chk({t, ".i_rdata"}, a.ird, e.ird);
    chk({t, ".d_rvalid"}, 32'(a.drv), 32'(e.drv));
    chk({t, ".d_rdata"}, a.drd, e.drd);
  endtask

  task automatic apply_resp(inout resp_t q[$], inout outs_t e);
    resp_t r;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      if (r.own_d) begin e.drv = 1'b1; e.drd = r.data; end
      else begin e.irv = 1'b1; e.ird = r.data; end
    end
  endtask

  // Transaction model: who wins, what the RAM sees, and which response is due this cycle.
  task automatic model_check();
    outs_t e, e2;
    bit gi, gd;
    e = '{default: '0};
    a1 = '{i_gnt1, d_gnt1, ram_ena1, ram_wea1, ram_addr1, ram_din1, stall1,
           i_rvalid1, i_rdata1, d_rvalid1, d_rdata1};
    a2 = '{i_gnt2, d_gnt2, ram_ena2, ram_wea2, ram_addr2, ram_din2, stall2,
           i_rvalid2, i_rdata2, d_rvalid2, d_rdata2};
    if (!rst) begin
      e2 = e;
      m_wait = 0; m_gi = 0; m_gd = 0;
      q1.delete(); q2.delete();
    end else begin
      if (i_req && d_req) begin
        gi = (m_wait == STARVE);
        gd = !gi;
      end else begin
        gi = i_req; gd = d_req;
      end
      e.gi = gi; e.gd = gd; e.ena = gi | gd;
      if (gd) begin e.wea = d_we; e.addr = d_addr; e.din = d_wdata; end
      else if (gi) e.addr = i_addr;
      e.stall = (i_req && !gi) || (d_req && !gd);
      e2 = e;
      apply_resp(q1, e);
      apply_resp(q2, e2);
      if (gi) begin
        q1.push_back('{cyc + 1, 1'b0, ref_mem[i_addr[5:0]]});
        q2.push_back('{cyc + 2, 1'b0, ref_mem[i_addr[5:0]]});
      end
      if (gd && d_we == 4'b0000) begin
        q1.push_back('{cyc + 1, 1'b1, ref_mem[d_addr[5:0]]});
        q2.push_back('{cyc + 2, 1'b1, ref_mem[d_addr[5:0]]});
      end
      if (gd)
        for (int b = 0; b < 4; b++)
          if (d_we[b]) ref_mem[d_addr[5:0]][8*b +: 8] = d_wdata[8*b +: 8];
      if (i_req && !gi) m_wait = (m_wait < STARVE) ? m_wait + 1 : m_wait;
      else m_wait = 0;
      m_gi = gi; m_gd = gd;
    end
    cmp_outs("lat1", a1, e);
    cmp_outs("lat2", a2, e2);
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 0; d_req = 0; d_we = 4'h0; step();
  endtask

  task automatic dreq(input logic [3:0] we, input logic [9:0] a, input logic [31:0] wd);
    i_req = 0; d_req = 1; d_we = we; d_addr = a; d_wdata = wd; step();
  endtask

  vec_t vecs[6];

  initial begin
    rst = 1; i_req = 0; d_req = 0; i_addr = '0; d_addr = '0; d_we = '0; d_wdata = '0;
    #2 rst = 0;
    @(posedge clk); #1;
    step(); step();
    rst = 1;

    for (int a = 0; a < 64; a++) dreq(4'hF, 10'(a), $urandom);
    idle();

    // Single-cycle arbitration table, each entry from an idle state.
    vecs[0] = '{1, 10'h005, 0, 4'h0, 10'h000, 32'h0,        1, 0, 4'h0, 10'h005, 32'h0, 0};
    vecs[1] = '{0, 10'h000, 1, 4'h0, 10'h007, 32'h0,        0, 1, 4'h0, 10'h007, 32'h0, 0};
    vecs[2] = '{0, 10'h000, 1, 4'hF, 10'h004, 32'h24020005, 0, 1, 4'hF, 10'h004,
                32'h24020005, 0};
    vecs[3] = '{1, 10'h003, 1, 4'h0, 10'h009, 32'h0,        0, 1, 4'h0, 10'h009, 32'h0, 1};
    vecs[4] = '{1, 10'h003, 1, 4'h3, 10'h008, 32'h12345678, 0, 1, 4'h3, 10'h008,
                32'h12345678, 1};
    vecs[5] = '{0, 10'h000, 0, 4'h0, 10'h000, 32'h0,        0, 0, 4'h0, 10'h000, 32'h0, 0};
    for (int v = 0; v < 6; v++) begin
      i_req = vecs[v].ir; i_addr = vecs[v].ia; d_req = vecs[v].dr; d_we = vecs[v].dwe;
      d_addr = vecs[v].da; d_wdata = vecs[v].dwd;
      step();
      chk("vec.i_gnt", 32'(a1.gi), 32'(vecs[v].egi));
      chk("vec.d_gnt", 32'(a1.gd), 32'(vecs[v].egd));
      chk("vec.ram_wea", 32'(a1.wea), 32'(vecs[v].ewea));
      chk("vec.ram_addr", 32'(a1.addr), 32'(vecs[v].eaddr));
      chk("vec.ram_din", a1.din, vecs[v].edin);
      chk("vec.stall", 32'(a1.stall), 32'(vecs[v].estall));
      idle();
    end

    // Fetch read of a known word.
    i_req = 1; i_addr = 10'h004; step();
    chk("fetch.i_gnt", 32'(a1.gi), 32'd1);
    idle();
    chk("fetch.i_rvalid", 32'(a1.irv), 32'd1);
    chk("fetch.i_rdata", a1.ird, 32'h24020005);
    chk("fetch.d_rvalid", 32'(a1.drv), 32'd0);

    // Full store then load back.
    dreq(4'hF, 10'h010, 32'hDEADBEEF);
    chk("store.ram_wea", 32'(a1.wea), 32'hF);
    chk("store.ram_din", a1.din, 32'hDEADBEEF);
    dreq(4'h0, 10'h010, 32'h0);
    chk("store.no_rvalid", 32'(a1.drv), 32'd0);
    idle();
    chk("load.d_rvalid", 32'(a1.drv), 32'd1);
    chk("load.d_rdata", a1.drd, 32'hDEADBEEF);

    // Starvation: data wins three times, then fetch.
    for (int k = 0; k < 5; k++) begin
      i_req = (k <= 3); i_addr = 10'h003; d_req = 1; d_we = 4'h0; d_addr = 10'h009;
      step();
      chk("starve.d_gnt", 32'(a1.gd), (k == 3) ? 32'd0 : 32'd1);
      chk("starve.i_gnt", 32'(a1.gi), (k == 3) ? 32'd1 : 32'd0);
      chk("starve.stall", 32'(a1.stall), (k < 4) ? 32'd1 : 32'd0);
    end
    idle(); idle();

    // READ_LAT=2 ordering: fetch, data read, fetch on consecutive cycles.
    dreq(4'hF, 10'h005, 32'h00000055);
    i_req = 1; d_req = 0; i_addr = 10'h004; step();
    i_req = 0; d_req = 1; d_we = 4'h0; d_addr = 10'h010; step();
    i_req = 1; d_req = 0; i_addr = 10'h005; step();
    chk("lat2.seq0.i_rvalid", 32'(a2.irv), 32'd1);
    chk("lat2.seq0.i_rdata", a2.ird, 32'h24020005);
    chk("lat2.seq0.d_rvalid", 32'(a2.drv), 32'd0);
    idle();
    chk("lat2.seq1.d_rvalid", 32'(a2.drv), 32'd1);
    chk("lat2.seq1.d_rdata", a2.drd, 32'hDEADBEEF);
    chk("lat2.seq1.i_rvalid", 32'(a2.irv), 32'd0);
    idle();
    chk("lat2.seq2.i_rvalid", 32'(a2.irv), 32'd1);
    chk("lat2.seq2.i_rdata", a2.ird, 32'h00000055);
    idle();

    // Partial store merge.
    dreq(4'hF, 10'h020, 32'h11111111);
    dreq(4'h3, 10'h020, 32'hAAAABBBB);
    dreq(4'h0, 10'h020, 32'h0);
    idle();
    chk("partial.d_rdata", a1.drd, 32'h1111BBBB);

    // Reset one cycle after a granted read discards it.
    i_req = 1; i_addr = 10'h004; step();
    rst = 0; i_req = 1; d_req = 1; d_we = 4'hF; step();
    chk("rst.i_gnt", 32'(a1.gi), 32'd0);
    chk("rst.d_gnt", 32'(a1.gd), 32'd0);
    chk("rst.ram_ena", 32'(a1.ena), 32'd0);
    chk("rst.stall", 32'(a1.stall), 32'd0);
    chk("rst.i_rvalid", 32'(a1.irv), 32'd0);
    rst = 1;
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("postrst.lat1.i_rvalid", 32'(a1.irv), 32'd0);
      chk("postrst.lat2.i_rvalid", 32'(a2.irv), 32'd0);
      chk("postrst.lat2.d_rvalid", 32'(a2.drv), 32'd0);
    end

    // Random traffic; requests are held until granted, with occasional drops and resets.
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      if (!(i_req && !m_gi) || $urandom_range(0, 15) == 0) begin
        i_req = ($urandom_range(0, 2) != 0);
        i_addr = 10'($urandom_range(0, 63));
      end
      if (!(d_req && !m_gd) || $urandom_range(0, 15) == 0) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_we = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
        d_addr = 10'($urandom_range(0, 63));
        d_wdata = $urandom;
      end
      step();
    end
    rst = 1;
    idle(); idle(); idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
